// File: rtl/fixed_width_cmp_monitor.sv
// fixed_width_cmp_monitor: aligns paired fixed-point channels to a common exponent and tracks tolerance violations.
module fixed_width_cmp_monitor #(
  parameter int NCH = 2,
  parameter int WA = 25,
  parameter int EA = -16,
  parameter int WB = 18,
  parameter int EB = -10,
  parameter int TOL = 64,
  parameter int SETTLE = 4,
  parameter int CNT_W = 8,
  localparam int EC = (EA < EB) ? EA : EB,
  localparam int SA = EA - EC,
  localparam int SB = EB - EC,
  localparam int WC = ((WA + SA > WB + SB) ? WA + SA : WB + SB) + 1,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [NCH*WA-1:0]  a_in,
  input  logic [NCH*WB-1:0]  b_in,
  output logic               armed,
  output logic [NCH-1:0]     mism,
  output logic               fail,
  output logic [CW-1:0]      fail_ch,
  output logic [CNT_W-1:0]   fail_idx,
  output logic [NCH*CNT_W-1:0] mism_cnt,
  output logic [WC-1:0]      max_dev
);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WC-1:0] TOLV = WC'(TOL);
  typedef enum logic [1:0] {S_SETTLE, S_ARMED, S_FAILED} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] idx_q, idx_d, fidx_q, fidx_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0] mism_q, mism_d, mis;
  logic [CW-1:0] fch_q, fch_d, fch;
  logic [WC-1:0] max_q, max_d, dmax;
  logic [WC-1:0] dev [NCH];
  logic chk;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic signed [WC-1:0] a_x, b_x;
    logic signed [WC:0] df;
    logic [WC:0] ad;
    assign a_x = WC'($signed(a_in[i*WA +: WA])) <<< SA;
    assign b_x = WC'($signed(b_in[i*WB +: WB])) <<< SB;
    assign df = (WC+1)'(a_x) - (WC+1)'(b_x);
    assign ad = df[WC] ? $unsigned(-df) : $unsigned(df);
    assign dev[i] = ad[WC] ? '1 : ad[WC-1:0];
    assign mis[i] = dev[i] > TOLV;
    assign mism_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
  // Iterating downward leaves the lowest mismatching channel in fch.
  always_comb begin
    dmax = '0;
    fch = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (dev[j] > dmax) dmax = dev[j];
      if (mis[j]) fch = CW'(j);
    end
  end
  assign chk = in_valid && !clear && state_q != S_SETTLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_SETTLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (clear) state_d = S_SETTLE;
    else if (state_q == S_SETTLE) begin
      if (SETTLE == 0 || (in_valid && settle_q == SW'(SETTLE - 1))) state_d = S_ARMED;
    end else if (state_q == S_ARMED && in_valid && |mis) state_d = S_FAILED;
  end
  always_comb begin
    armed = state_q != S_SETTLE;
    fail = state_q == S_FAILED;
  end
  always_comb begin
    settle_d = settle_q;
    idx_d = idx_q;
    mism_d = mism_q;
    fch_d = fch_q;
    fidx_d = fidx_q;
    max_d = max_q;
    cnt_d = cnt_q;
    if (clear) begin
      settle_d = '0;
      idx_d = '0;
      mism_d = '0;
      fch_d = '0;
      fidx_d = '0;
      max_d = '0;
      for (int j = 0; j < NCH; j++) cnt_d[j] = '0;
    end else if (in_valid && state_q == S_SETTLE) begin
      settle_d = settle_q + 1'b1;
    end else if (chk) begin
      mism_d = mis;
      idx_d = (idx_q == '1) ? idx_q : idx_q + 1'b1;
      max_d = (dmax > max_q) ? dmax : max_q;
      if (state_q == S_ARMED && |mis) begin
        fch_d = fch;
        fidx_d = idx_q;
      end
      for (int j = 0; j < NCH; j++) cnt_d[j] = (mis[j] && cnt_q[j] != '1) ? cnt_q[j] + 1'b1 : cnt_q[j];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      idx_q <= '0;
      mism_q <= '0;
      fch_q <= '0;
      fidx_q <= '0;
      max_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      settle_q <= settle_d;
      idx_q <= idx_d;
      mism_q <= mism_d;
      fch_q <= fch_d;
      fidx_q <= fidx_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
    end
  end
  assign mism = mism_q;
  assign fail_ch = fch_q;
  assign fail_idx = fidx_q;
  assign max_dev = max_q;
endmodule

// File: tb/tb_fixed_width_cmp_monitor.sv
// tb_fixed_width_cmp_monitor: scoreboard bench with an independent real-value model, CNT_W=4.
module tb_fixed_width_cmp_monitor;
  logic clk = 0, rst = 0, clear = 0, in_valid = 0;
  logic [49:0] a_in = '0;
  logic [35:0] b_in = '0;
  logic armed, fail;
  logic [1:0] mism;
  logic [0:0] fail_ch;
  logic [3:0] fail_idx;
  logic [7:0] mism_cnt;
  logic [25:0] max_dev;
  int checks = 0, errors = 0;
  typedef struct {
    logic armed; logic [1:0] mism; logic fail; logic fch;
    logic [3:0] fidx; logic [3:0] c0, c1; logic [25:0] md;
  } exp_t;
  exp_t q[$];
  int m_sc, m_idx, m_c0, m_c1, m_fidx;
  logic m_armed, m_fail, m_fch;
  logic [1:0] m_mism;
  longint m_md;
  localparam logic [24:0] A1 = 25'h10000;
  localparam logic [17:0] B1 = 18'h400;

  fixed_width_cmp_monitor #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
    .armed(armed), .mism(mism), .fail(fail), .fail_ch(fail_ch), .fail_idx(fail_idx),
    .mism_cnt(mism_cnt), .max_dev(max_dev)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sc = 0; m_idx = 0; m_c0 = 0; m_c1 = 0; m_fidx = 0;
    m_armed = 0; m_fail = 0; m_fch = 0; m_mism = 0; m_md = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".armed"}, armed, 0);
    check({tag, ".mism"}, mism, 0);
    check({tag, ".fail"}, fail, 0);
    check({tag, ".fail_ch"}, fail_ch, 0);
    check({tag, ".fail_idx"}, fail_idx, 0);
    check({tag, ".mism_cnt"}, mism_cnt, 0);
    check({tag, ".max_dev"}, max_dev, 0);
  endtask

  task automatic send(input string tag, input logic v, input logic clr,
                      input logic [24:0] a0, input logic [24:0] a1,
                      input logic [17:0] b0, input logic [17:0] b1);
    exp_t e, g;
    longint d0, d1;
    logic [1:0] mm;
    @(negedge clk);
    in_valid = v; clear = clr; a_in = {a1, a0}; b_in = {b1, b0};
    d0 = longint'($signed(a0)) - 64 * longint'($signed(b0));
    d1 = longint'($signed(a1)) - 64 * longint'($signed(b1));
    if (d0 < 0) d0 = -d0;
    if (d1 < 0) d1 = -d1;
    mm = {d1 > 64, d0 > 64};
    if (clr) model_reset();
    else if (v && !m_armed) begin
      m_sc++;
      if (m_sc == 4) m_armed = 1;
    end else if (v) begin
      if (!m_fail && mm != 0) begin
        m_fail = 1; m_fch = !mm[0]; m_fidx = m_idx;
      end
      if (mm[0] && m_c0 < 15) m_c0++;
      if (mm[1] && m_c1 < 15) m_c1++;
      if (d0 > m_md) m_md = d0;
      if (d1 > m_md) m_md = d1;
      m_mism = mm;
      if (m_idx < 15) m_idx++;
    end
    e.armed = m_armed; e.mism = m_mism; e.fail = m_fail; e.fch = m_fch;
    e.fidx = 4'(m_fidx); e.c0 = 4'(m_c0); e.c1 = 4'(m_c1); e.md = 26'(m_md);
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check({tag, ".armed"}, armed, g.armed);
    check({tag, ".mism"}, mism, g.mism);
    check({tag, ".fail"}, fail, g.fail);
    check({tag, ".fail_ch"}, fail_ch, g.fch);
    check({tag, ".fail_idx"}, fail_idx, g.fidx);
    check({tag, ".cnt0"}, mism_cnt[3:0], g.c0);
    check({tag, ".cnt1"}, mism_cnt[7:4], g.c1);
    check({tag, ".max_dev"}, max_dev, g.md);
  endtask

  task automatic settle_eq(input string tag);
    send({tag, ".clr"}, 1, 1, A1, A1, B1, B1);
    for (int i = 0; i < 4; i++) send({tag, ".settle"}, 1, 0, A1, A1, B1, B1);
  endtask

  initial begin
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 20; i++) send("exact", 1, 0, A1, A1, B1, B1);
    send("exact_neg", 1, 0, 25'h1FF0000, 25'h1FF0000, 18'h3FC00, 18'h3FC00);
    send("hold", 0, 0, A1, A1, 18'h0, 18'h0);
    send("mask.clr", 1, 1, A1, A1, B1, B1);
    for (int i = 0; i < 4; i++) send("mask.bad", 1, 0, A1, A1, 18'h200, 18'h200);
    for (int i = 0; i < 6; i++) send("mask.eq", 1, 0, A1, A1, B1, B1);
    settle_eq("first");
    for (int i = 0; i < 3; i++) send("first.eq", 1, 0, A1, A1, B1, B1);
    send("first.ch1", 1, 0, A1, A1, B1, 18'h402);
    send("first.eq4", 1, 0, A1, A1, B1, B1);
    send("first.ch0", 1, 0, A1, A1, 18'h402, B1);
    check("first.fail_ch_frozen", fail_ch, 1);
    check("first.fail_idx_frozen", fail_idx, 3);
    settle_eq("tol");
    send("tol.64", 1, 0, 25'h10040, A1, B1, B1);
    send("tol.65", 1, 0, 25'h10041, A1, B1, B1);
    check("tol.max65", max_dev, 65);
    settle_eq("sat");
    for (int i = 0; i < 20; i++) send("sat.ch0", 1, 0, 25'h20000, A1, B1, B1);
    check("sat.cnt0_15", mism_cnt[3:0], 15);
    settle_eq("both");
    send("both.fail", 1, 0, 25'h20000, 25'h20000, B1, B1);
    check("both.fail_ch0", fail_ch, 0);
    settle_eq("rnd");
    for (int i = 0; i < 16; i++) begin
      logic signed [17:0] bs;
      longint av;
      bs = 18'($urandom);
      av = 64 * longint'(bs) + longint'($urandom_range(200)) - 100;
      send("rnd", (i % 4) != 3, 0, 25'(av), 25'(av + 7), bs, bs);
    end
    send("clrfail", 1, 1, 25'h20000, 25'h20000, B1, B1);
    check_zero("clrfail");
    for (int i = 0; i < 5; i++) send("pre_rst", 1, 0, 25'h20000, A1, B1, B1);
    @(negedge clk);
    #2 rst = 0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1;
    send("post_rst", 1, 0, A1, A1, B1, B1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
